// File: rtl/register_file.sv
// 32-entry register file: one synchronous write port, two combinational
// read ports, x0 hardwired to zero, optional write-to-read bypass.
module register_file #(
    parameter int unsigned N      = 32,
    parameter bit          BYPASS = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_ena,
    input  logic [4:0]   wr_addr,
    input  logic [N-1:0] wr_data,
    input  logic [4:0]   rd_addr0,
    output logic [N-1:0] rd_data0,
    input  logic [4:0]   rd_addr1,
    output logic [N-1:0] rd_data1
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;

    logic [NREG-1:0] w_we;
    logic [N-1:0]    r_x [NREG-1:1];
    logic [N-1:0]    w_rd0;
    logic [N-1:0]    w_rd1;
    logic            w_byp_live;

    // One-hot write enable; bit 0 never set so x0 cannot be written, and an
    // unknown address with the enable low decodes to all zeros.
    always_comb begin
        w_we = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            if (wr_ena && (wr_addr == AW'(i))) begin
                w_we[i] = 1'b1;
            end
        end
    end

    // Register storage: asynchronous clear, single-register update per edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < int'(NREG); i++) begin
                r_x[i] <= '0;
            end
        end else begin
            for (int i = 1; i < int'(NREG); i++) begin
                if (w_we[i]) begin
                    r_x[i] <= wr_data;
                end
            end
        end
    end

    // Read port 0 mux; address 0 falls through to the zero default.
    always_comb begin
        w_rd0 = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            if (rd_addr0 == AW'(i)) begin
                w_rd0 = r_x[i];
            end
        end
    end

    // Read port 1 mux; address 0 falls through to the zero default.
    always_comb begin
        w_rd1 = '0;
        for (int i = 1; i < int'(NREG); i++) begin
            if (rd_addr1 == AW'(i)) begin
                w_rd1 = r_x[i];
            end
        end
    end

    // A write only forwards when it will actually land: not to x0, not in reset.
    always_comb begin
        w_byp_live = BYPASS && wr_ena && rst_n && (wr_addr != '0);
    end

    // Final read selection with optional same-cycle forwarding of write data.
    always_comb begin
        rd_data0 = w_rd0;
        rd_data1 = w_rd1;
        if (w_byp_live && (rd_addr0 == wr_addr)) begin
            rd_data0 = wr_data;
        end
        if (w_byp_live && (rd_addr1 == wr_addr)) begin
            rd_data1 = wr_data;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Randomized and directed checks of register_file, with both bypass settings
// instantiated side by side on shared stimulus.
module tb_register_file;

    logic        clk;
    logic        rst_n;
    logic        wr_ena;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [4:0]  rd_addr0;
    logic [4:0]  rd_addr1;
    logic [31:0] rd0_nb, rd1_nb;   // BYPASS=0 instance
    logic [31:0] rd0_by, rd1_by;   // BYPASS=1 instance

    int checks   = 0;
    int failures = 0;

    logic [31:0] mdl [32];

    register_file #(.N(32), .BYPASS(1'b0)) u_nb (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_data0(rd0_nb),
        .rd_addr1(rd_addr1), .rd_data1(rd1_nb)
    );

    register_file #(.N(32), .BYPASS(1'b1)) u_by (
        .clk(clk), .rst_n(rst_n), .wr_ena(wr_ena), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr0(rd_addr0), .rd_data0(rd0_by),
        .rd_addr1(rd_addr1), .rd_data1(rd1_by)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference contents: an array that a reset wipes and a valid write updates.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mdl[i] <= 32'h0;
        end else if (wr_ena && wr_addr != 5'd0) begin
            mdl[wr_addr] <= wr_data;
        end
    end

    function automatic logic [31:0] expect_rd(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && rst_n && wr_ena && a == wr_addr) return wr_data;
        return mdl[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Every cycle, mid-period: both instances, both ports against the model.
    always @(negedge clk) begin
        chk("nb_port0", rd0_nb, expect_rd(rd_addr0, 1'b0));
        chk("nb_port1", rd1_nb, expect_rd(rd_addr1, 1'b0));
        chk("by_port0", rd0_by, expect_rd(rd_addr0, 1'b1));
        chk("by_port1", rd1_by, expect_rd(rd_addr1, 1'b1));
    end

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_ena  = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr0 = '0; rd_addr1 = '0;
        tick(); tick();
        rst_n = 1'b1;
        rd_addr0 = 5'd5;
        #1 chk("after_reset_x5", rd0_nb, 32'h0);

        // Asynchronous clear, mid-cycle, no clock edge involved.
        wr(5'd5, 32'hDEADBEEF);
        #1 chk("x5_written", rd0_nb, 32'hDEADBEEF);
        rst_n = 1'b0;
        #1 chk("async_clear_nb", rd0_nb, 32'h0);
        chk("async_clear_by", rd0_by, 32'h0);
        rst_n = 1'b1;
        tick();

        // Fill every register, then sweep both ports.
        for (int i = 1; i < 32; i++) wr(5'(i), 32'(i) * 32'h01010101);
        for (int i = 0; i < 32; i++) begin
            rd_addr0 = 5'(i);
            rd_addr1 = 5'(31 - i);
            #1;
            chk("sweep_p0", rd0_nb, 32'(i) * 32'h01010101);
            chk("sweep_p1", rd1_by, 32'(31 - i) * 32'h01010101);
        end
        rd_addr0 = 5'd7; rd_addr1 = 5'd7;
        #1 chk("same_addr_p0", rd0_nb, 32'h07070707);
        chk("same_addr_p1", rd1_nb, 32'h07070707);

        // x0 immunity, before and after the edge, both bypass settings.
        rd_addr0 = 5'd0;
        wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        #1 chk("x0_pre_by", rd0_by, 32'h0);
        tick();
        wr_ena = 1'b0;
        chk("x0_post_nb", rd0_nb, 32'h0);
        chk("x0_post_by", rd0_by, 32'h0);

        // Enable gating.
        wr(5'd3, 32'hABCD);
        wr_addr = 5'd3; wr_data = 32'h1234; rd_addr0 = 5'd3;
        repeat (4) tick();
        chk("gated_nb", rd0_nb, 32'hABCD);
        chk("gated_by", rd0_by, 32'hABCD);

        // Same-cycle read of the register being written.
        wr(5'd9, 32'h11);
        rd_addr1 = 5'd9;
        wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h22;
        #1 chk("rw_pre_nb", rd1_nb, 32'h11);
        chk("rw_pre_by", rd1_by, 32'h22);
        tick();
        wr_ena = 1'b0;
        chk("rw_post_nb", rd1_nb, 32'h22);

        // Write held across an edge under reset is dropped; next edge lands.
        rd_addr0 = 5'd4;
        rst_n = 1'b0;
        wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
        tick();
        rst_n = 1'b1;
        #1 chk("drop_x4", rd0_nb, 32'h0);
        tick();
        wr_ena = 1'b0;
        chk("land_x4", rd0_nb, 32'h55);

        // Random traffic with occasional reset pulses.
        for (int n = 0; n < 600; n++) begin
            wr_ena   = ($urandom_range(0, 3) != 0);
            wr_addr  = 5'($urandom_range(0, 31));
            wr_data  = $urandom;
            rd_addr0 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            rd_addr1 = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 59) == 0) begin
                #1 rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
            end else begin
                tick();
            end
        end
        wr_ena = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
